// File: rtl/brent_kung_pipe_subtractor.sv
// brent_kung_pipe_subtractor
//   Two-stage pipelined Brent-Kung prefix subtractor: Diff = A - B - Bin.
//   The difference is formed as A + ~B + ~Bin. Generate and propagate terms
//   come from A and ~B, and the carry-in ~Bin is folded into bit 0's generate.
//   The up-sweep half of the prefix tree sits in front of the first register
//   stage. The down-sweep, the sum, and the flags sit in front of the second
//   register stage, which drives the outputs.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand A/B/Bin present
//   in_ready   operand accepted on this edge if in_valid is high
//   A, B       minuend and subtrahend, WIDTH bits
//   Bin        borrow-in
//   out_valid  Diff/Bout/Ovf valid
//   out_ready  downstream takes the result on this edge
//   Diff       (A - B - Bin) mod 2^WIDTH
//   Bout       unsigned borrow out (A < B + Bin)
//   Ovf        two's-complement overflow of the subtraction
module brent_kung_pipe_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int LOG = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  // ---------------------------------------------------------------------------
  // Stage p0: bit terms and prefix up-sweep (levels 1..LOG)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] g_p0, p_p0;
  logic [WIDTH-1:0] gu_p0, pu_p0;
  logic             cin_p0;

  always_comb begin
    cin_p0 = ~Bin;
    g_p0   = A & ~B;
    p_p0   = A ^ ~B;
    gu_p0  = g_p0;
    pu_p0  = p_p0;
    // Folding the carry-in into bit 0 makes every prefix group that ends at
    // bit 0 a true carry, so the tree needs no extra input.
    gu_p0[0] = g_p0[0] | (p_p0[0] & cin_p0);
    // At level l, each node whose index+1 is a multiple of 2^l combines its
    // group with the group that ends 2^(l-1) bits lower. In-place update is
    // safe because the partner is never itself a target at the same level.
    for (int l = 1; l <= LOG; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (1 << l)) == 0) begin
          gu_p0[i] = gu_p0[i] | (pu_p0[i] & gu_p0[i - (1 << (l - 1))]);
          pu_p0[i] = pu_p0[i] & pu_p0[i - (1 << (l - 1))];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1 register: up-sweep results plus the raw propagate for the sum
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] p_p1, gu_p1, pu_p1;
  logic             cin_p1, amsb_p1, bmsb_p1;
  logic             vld_p1;
  logic             s2_adv, s2_load, in_fire;

  assign s2_adv   = ~out_valid | out_ready;
  assign in_ready = ~vld_p1 | s2_adv;
  assign s2_load  = vld_p1 & s2_adv;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_fire) begin
      vld_p1 <= 1'b1;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      p_p1    <= p_p0;
      gu_p1   <= gu_p0;
      pu_p1   <= pu_p0;
      cin_p1  <= cin_p0;
      amsb_p1 <= A[MSB];
      bmsb_p1 <= B[MSB];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1 combinational: down-sweep (levels LOG-1..1), sum and flags
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] gd_p1, pd_p1, carry_p1, sum_p1;
  logic             bout_p1, ovf_p1;

  always_comb begin
    gd_p1 = gu_p1;
    pd_p1 = pu_p1;
    // The down-sweep fills the nodes midway between the up-sweep roots at each
    // level. Indices below 3*2^(l-1)-1 already hold complete prefixes.
    for (int l = LOG - 1; l >= 1; l--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((i >= (3 << (l - 1)) - 1) && (((i + 1) % (1 << l)) == (1 << (l - 1)))) begin
          gd_p1[i] = gd_p1[i] | (pd_p1[i] & gd_p1[i - (1 << (l - 1))]);
          pd_p1[i] = pd_p1[i] & pd_p1[i - (1 << (l - 1))];
        end
      end
    end
    carry_p1 = {gd_p1[MSB-1:0], cin_p1};
    sum_p1   = p_p1 ^ carry_p1;
    bout_p1  = ~gd_p1[MSB];
    ovf_p1   = (amsb_p1 != bmsb_p1) && (sum_p1[MSB] != amsb_p1);
  end

  // ---------------------------------------------------------------------------
  // Stage p2 register: outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Diff      <= '0;
      Bout      <= 1'b0;
      Ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      Diff      <= sum_p1;
      Bout      <= bout_p1;
      Ovf       <= ovf_p1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_brent_kung_pipe_subtractor.sv
// tb_brent_kung_pipe_subtractor
//   Drives brent_kung_pipe_subtractor (WIDTH=16) with directed and $urandom
//   operand streams and compares every delivered result against a plain
//   integer-arithmetic reference model held in an in-order queue.
module tb_brent_kung_pipe_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Diff;
  logic        Bout;
  logic        Ovf;

  brent_kung_pipe_subtractor #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout),
    .Ovf       (Ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
  } op_t;

  typedef struct {
    op_t         o;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  op_t  ops[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   abort = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned difference and borrow from integer arithmetic,
  // overflow from whether the signed result leaves the 16-bit range.
  function automatic exp_t model(input op_t o);
    exp_t r;
    int   ua, ub, sa, sbv, bi, ud, sd;
    ua  = {16'd0, o.a};
    ub  = {16'd0, o.b};
    sa  = int'($signed(o.a));
    sbv = int'($signed(o.b));
    bi  = {31'd0, o.bin};
    ud  = ua - ub - bi;
    sd  = sa - sbv - bi;
    r.o  = o;
    r.d  = ud[15:0];
    r.bo = (ua < ub + bi);
    r.ov = (sd < -32768) || (sd > 32767);
    return r;
  endfunction

  task automatic add(input logic [15:0] a, input logic [15:0] b, input logic bin);
    op_t t;
    t.a   = a;
    t.b   = b;
    t.bin = bin;
    ops.push_back(t);
  endtask

  // Streams the queued operands back-to-back and checks ordering, holding
  // under backpressure, and the in_ready rule against the occupancy count.
  task automatic stream(input bit rand_rdy, input bit stop_on_bad, input int max_cycles);
    int          idx;
    int          cyc;
    bit          fired;
    bit          hold;
    logic [15:0] hd;
    logic        hbo, hov;
    exp_t        e;
    bit          ok;
    idx = 0; cyc = 0; fired = 0; hold = 0; hd = '0; hbo = 1'b0; hov = 1'b0;
    in_valid = 1'b0;
    while ((idx < ops.size() || sb.size() != 0) && !abort) begin
      @(negedge clk);
      if (fired) begin
        in_valid = 1'b0;
        fired = 0;
      end
      if (cyc == max_cycles) begin
        chk("stream_budget_left", 32'(sb.size() + ops.size() - idx), 32'd0);
        abort = 1;
        break;
      end
      cyc++;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!in_valid && idx < ops.size()) begin
        A   = ops[idx].a;
        B   = ops[idx].b;
        Bin = ops[idx].bin;
        in_valid = 1'b1;
      end
      #1;
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_diff",  32'(Diff), 32'(hd));
        chk("hold_bout",  32'(Bout), 32'(hbo));
        chk("hold_ovf",   32'(Ovf),  32'(hov));
      end
      chk("in_ready", 32'(in_ready), 32'(!(sb.size() == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        chk("out_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e  = sb.pop_front();
          ok = (Diff === e.d) && (Bout === e.bo) && (Ovf === e.ov);
          chk("diff", 32'(Diff), 32'(e.d));
          chk("bout", 32'(Bout), 32'(e.bo));
          chk("ovf",  32'(Ovf),  32'(e.ov));
          if (!ok && stop_on_bad) begin
            $display("first bad operands: A=%0d B=%0d Bin=%0d", e.o.a, e.o.b, e.o.bin);
            abort = 1;
          end
        end
      end
      hold = out_valid && !out_ready;
      hd   = Diff;
      hbo  = Bout;
      hov  = Ovf;
      if (in_valid && in_ready) begin
        sb.push_back(model(ops[idx]));
        idx++;
        fired = 1;
      end
    end
    in_valid = 1'b0;
    ops.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t  r1, r2;
    exp_t e1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Bin = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_diff",      32'(Diff),      32'd0);
    chk("rst_bout",      32'(Bout),      32'd0);
    chk("rst_ovf",       32'(Ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed wrap-around and borrow-in cases
    add(16'd1000,   16'd1,      1'b0);
    add(16'h0000,   16'h0001,   1'b0);
    add(16'h8000,   16'h0001,   1'b0);
    add(16'd5,      16'd5,      1'b1);
    add(16'd5,      16'd4,      1'b1);
    add(16'h7FFF,   16'hFFFF,   1'b0);
    add(16'hFFFF,   16'hFFFF,   1'b1);
    add(16'h0000,   16'h0000,   1'b1);
    stream(1'b0, 1'b0, 100);

    // 100 random operands with random backpressure
    for (int i = 0; i < 100; i++)
      add(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    if (!abort) stream(1'b1, 1'b0, 1000);

    // Asynchronous reset with both stages holding data
    r1.a = 16'h8000; r1.b = 16'h0001; r1.bin = 1'b1;
    r2.a = 16'h1234; r2.b = 16'h0042; r2.bin = 1'b0;
    e1 = model(r1);
    @(negedge clk);
    out_ready = 1'b0;
    A = r1.a; B = r1.b; Bin = r1.bin; in_valid = 1'b1;
    @(negedge clk);
    A = r2.a; B = r2.b; Bin = r2.bin;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid",    32'(out_valid), 32'd1);
    chk("pre_rst_in_ready", 32'(in_ready),  32'd0);
    chk("pre_rst_diff",     32'(Diff),      32'(e1.d));
    chk("pre_rst_ovf",      32'(Ovf),       32'(e1.ov));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid",    32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready),  32'd1);
    chk("async_rst_diff",     32'(Diff),      32'd0);
    chk("async_rst_bout",     32'(Bout),      32'd0);
    chk("async_rst_ovf",      32'(Ovf),       32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_held_valid", 32'(out_valid), 32'd0);

    // First accept right after release, then two-stage latency
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    A = 16'd1000; B = 16'd1; Bin = 1'b0; in_valid = 1'b1;
    #1;
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("lat_valid_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("lat_valid_c2", 32'(out_valid), 32'd1);
    chk("lat_diff",     32'(Diff),      32'd999);
    chk("lat_bout",     32'(Bout),      32'd0);
    chk("lat_ovf",      32'(Ovf),       32'd0);
    @(negedge clk);
    #1;
    chk("lat_drained", 32'(out_valid), 32'd0);

    // Sampled sweep of A and B over 0..1023, random borrow-in
    add(16'd0,    16'd1023, 1'b1);
    add(16'd1023, 16'd0,    1'b1);
    add(16'd1023, 16'd1023, 1'b0);
    add(16'd0,    16'd0,    1'b0);
    for (int ia = 0; ia < 64; ia++)
      for (int ib = 0; ib < 64; ib++)
        add(16'(ia * 16 + int'($urandom_range(0, 15))),
            16'(ib * 16 + int'($urandom_range(0, 15))),
            1'($urandom_range(0, 1)));
    if (!abort) stream(1'b0, 1'b1, 5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
